// File: rtl/pong_pkg.sv
// pong_pkg: definitions shared by the paddle sampling path.
//   state_t       - conversion scheduler FSM states
//   ADC_W         - width of an ADC conversion result
//   COORD_W       - width of a paddle Y coordinate
//   Y_MAX_DEFAULT - default paddle Y range (480 lines minus paddle height)
package pong_pkg;

  localparam int ADC_W         = 8;
  localparam int COORD_W       = 10;
  localparam int Y_MAX_DEFAULT = 400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_STORE
  } state_t;

endpackage

// File: rtl/paddle_filter.sv
// paddle_filter: combinational scale-and-smooth step for one paddle.
//   adc_data  in   raw 8-bit conversion result
//   filt      in   current filtered Y of the channel being updated
//   filt_new  out  next filtered Y: (3*filt + (adc_data*Y_MAX >> 8)) >> 2
module paddle_filter
  import pong_pkg::*;
#(
  parameter int Y_MAX = Y_MAX_DEFAULT
) (
  input  logic [ADC_W-1:0]   adc_data,
  input  logic [COORD_W-1:0] filt,
  output logic [COORD_W-1:0] filt_new
);

  logic [17:0]        product;
  logic [COORD_W-1:0] yraw;
  logic [11:0]        sum;

  // 8x10 product needs 18 bits; dropping the low byte keeps yraw below Y_MAX.
  // 3*1023 + 1023 still fits in 12 bits, so the IIR sum never overflows.
  always_comb begin
    product  = 18'(adc_data) * 18'(Y_MAX);
    yraw     = COORD_W'(product >> 8);
    sum      = 12'(filt) * 12'd3 + 12'(yraw);
    filt_new = COORD_W'(sum >> 2);
  end

endmodule

// File: rtl/paddle_sampler.sv
// paddle_sampler: schedules ADC conversions, alternating player channels,
// smooths the results and publishes paddle positions on frame boundaries.
//   clock_50MHz  in   system clock
//   rst          in   asynchronous active-high reset
//   adc_start    out  one-cycle conversion request
//   adc_ch       out  channel select, stable for a whole conversion
//   adc_busy     in   ADC busy (rise = accepted, fall = data valid)
//   adc_data     in   conversion result, valid when busy first falls
//   frame_start  in   one-cycle pulse at start of vertical blanking
//   y1, y2       out  published paddle positions
//   fresh        out  one-cycle pulse when a publish carries new samples
//   err          out  sticky ADC timeout flag
module paddle_sampler
  import pong_pkg::*;
#(
  parameter int SAMPLE_DIV = 50000,
  parameter int Y_MAX      = Y_MAX_DEFAULT,
  parameter int TIMEOUT    = 4096
) (
  input  logic               clock_50MHz,
  input  logic               rst,
  output logic               adc_start,
  output logic               adc_ch,
  input  logic               adc_busy,
  input  logic [ADC_W-1:0]   adc_data,
  input  logic               frame_start,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] y2,
  output logic               fresh,
  output logic               err
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [COORD_W-1:0] Y_MID = COORD_W'(Y_MAX / 2);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   rate_cnt_q, rate_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               adc_start_q, adc_start_d;
  logic               adc_ch_q, adc_ch_d;
  logic               err_q, err_d;
  logic               fresh_q, fresh_d;
  logic               pending_q, pending_d;
  logic [ADC_W-1:0]   data_q, data_d;
  logic [COORD_W-1:0] filt1_q, filt1_d, filt2_q, filt2_d;
  logic [COORD_W-1:0] shadow1_q, shadow1_d, shadow2_q, shadow2_d;
  logic [COORD_W-1:0] y1_q, y1_d, y2_q, y2_d;
  logic [COORD_W-1:0] filt_cur, filt_new;
  logic               tick, timed_out;

  // One filter instance serves both players; the active channel picks the state.
  assign filt_cur = adc_ch_q ? filt2_q : filt1_q;

  paddle_filter #(.Y_MAX(Y_MAX)) u_filter (
    .adc_data (data_q),
    .filt     (filt_cur),
    .filt_new (filt_new)
  );

  assign tick      = (rate_cnt_q == DIV_W'(SAMPLE_DIV - 1));
  assign timed_out = (wait_cnt_q == WAIT_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    rate_cnt_d  = tick ? '0 : rate_cnt_q + 1'b1;
    wait_cnt_d  = wait_cnt_q;
    adc_start_d = 1'b0;
    adc_ch_d    = adc_ch_q;
    err_d       = err_q;
    fresh_d     = frame_start & pending_q;
    pending_d   = pending_q;
    data_d      = data_q;
    filt1_d     = filt1_q;
    filt2_d     = filt2_q;
    shadow1_d   = shadow1_q;
    shadow2_d   = shadow2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;

    // Publishing reads the shadows before any STORE in the same cycle lands,
    // and a coincident STORE re-arms pending below so it publishes next frame.
    if (frame_start) begin
      y1_d      = shadow1_q;
      y2_d      = shadow2_q;
      pending_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d     = ST_START;
          adc_start_d = 1'b1;
        end
      end
      ST_START: begin
        state_d    = ST_WAIT_ACK;
        wait_cnt_d = '0;
      end
      ST_WAIT_ACK, ST_WAIT_DONE: begin
        // A single budget covers both the handshake and the conversion.
        if (timed_out) begin
          err_d    = 1'b1;
          adc_ch_d = ~adc_ch_q;
          state_d  = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (state_q == ST_WAIT_ACK && adc_busy) begin
            state_d = ST_WAIT_DONE;
          end else if (state_q == ST_WAIT_DONE && !adc_busy) begin
            data_d  = adc_data;
            state_d = ST_STORE;
          end
        end
      end
      ST_STORE: begin
        if (adc_ch_q) begin
          filt2_d   = filt_new;
          shadow2_d = filt_new;
        end else begin
          filt1_d   = filt_new;
          shadow1_d = filt_new;
        end
        pending_d = 1'b1;
        adc_ch_d  = ~adc_ch_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_50MHz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rate_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      adc_start_q <= 1'b0;
      adc_ch_q    <= 1'b0;
      err_q       <= 1'b0;
      fresh_q     <= 1'b0;
      pending_q   <= 1'b0;
      data_q      <= '0;
      filt1_q     <= Y_MID;
      filt2_q     <= Y_MID;
      shadow1_q   <= Y_MID;
      shadow2_q   <= Y_MID;
      y1_q        <= Y_MID;
      y2_q        <= Y_MID;
    end else begin
      state_q     <= state_d;
      rate_cnt_q  <= rate_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      adc_start_q <= adc_start_d;
      adc_ch_q    <= adc_ch_d;
      err_q       <= err_d;
      fresh_q     <= fresh_d;
      pending_q   <= pending_d;
      data_q      <= data_d;
      filt1_q     <= filt1_d;
      filt2_q     <= filt2_d;
      shadow1_q   <= shadow1_d;
      shadow2_q   <= shadow2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
    end
  end

  assign adc_start = adc_start_q;
  assign adc_ch    = adc_ch_q;
  assign err       = err_q;
  assign fresh     = fresh_q;
  assign y1        = y1_q;
  assign y2        = y2_q;

endmodule

// File: tb/tb_paddle_sampler.sv
// tb_paddle_sampler: directed checks of paddle_sampler with a scripted ADC.
// Small SAMPLE_DIV/TIMEOUT keep the run short; all expected values are
// hand-computed for Y_MAX=400 (reset Y = 200).
module tb_paddle_sampler;

  localparam int SAMPLE_DIV = 100;
  localparam int TIMEOUT    = 30;
  localparam int Y_MAX      = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       adc_start, adc_ch, fresh, err;
  logic       adc_busy = 1'b0;
  logic [7:0] adc_data = 8'd0;
  logic       frame_start = 1'b0;
  logic [9:0] y1, y2;

  int checks = 0;
  int errors = 0;

  paddle_sampler #(.SAMPLE_DIV(SAMPLE_DIV), .Y_MAX(Y_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clock_50MHz (clk),
    .rst         (rst),
    .adc_start   (adc_start),
    .adc_ch      (adc_ch),
    .adc_busy    (adc_busy),
    .adc_data    (adc_data),
    .frame_start (frame_start),
    .y1          (y1),
    .y2          (y2),
    .fresh       (fresh),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Hold reset across one edge, release mid-cycle.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; adc_busy = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ADC model: wait for a request, hold busy for busy_len edges, then drop it
  // with data. Returns after the STORE edge, optionally pulsing frame_start on it.
  task automatic adc_service(input int busy_len, input logic [7:0] data,
                             input bit frame_at_store, output logic ch_seen,
                             output bit stable, output bit ok);
    ok = 1'b0; stable = 1'b1; ch_seen = 1'b0;
    for (int i = 0; i < 3 * SAMPLE_DIV; i++) begin
      @(posedge clk); #1;
      if (adc_start === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    ch_seen  = adc_ch;
    adc_busy = 1'b1;
    repeat (busy_len) begin
      @(posedge clk); #1;
      if (adc_ch !== ch_seen) stable = 1'b0;
    end
    adc_busy = 1'b0;
    adc_data = data;
    @(posedge clk); #1;
    if (adc_ch !== ch_seen) stable = 1'b0;
    if (frame_at_store) frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pulse_frame(output logic [9:0] o_y1, output logic [9:0] o_y2,
                             output logic o_fresh, output logic o_fresh_next);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    o_y1 = y1; o_y2 = y2; o_fresh = fresh;
    @(posedge clk); #1;
    o_fresh_next = fresh;
  endtask

  task automatic test_reset();
    bit early;
    @(posedge clk); #1;
    checks++; if (y1 !== 10'd200) begin errors++; $display("[TB] FAIL reset_y1 got %0d expected 200", y1); end
    checks++; if (y2 !== 10'd200) begin errors++; $display("[TB] FAIL reset_y2 got %0d expected 200", y2); end
    checks++; if ({err, fresh, adc_start, adc_ch} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got %b expected 0000", {err, fresh, adc_start, adc_ch}); end
    rst = 1'b0;
    early = 1'b0;
    for (int k = 1; k < SAMPLE_DIV; k++) begin
      @(posedge clk); #1;
      if (adc_start !== 1'b0) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("[TB] FAIL start_early got 1 expected 0"); end
    @(posedge clk); #1;
    checks++; if (adc_start !== 1'b1) begin errors++; $display("[TB] FAIL first_start got %b expected 1", adc_start); end
  endtask

  task automatic test_single_ch0();
    logic ch; bit st, ok; logic [9:0] a, b; logic f, fn;
    do_reset();
    adc_service(20, 8'd255, 1'b0, ch, st, ok);
    checks++; if (!ok || ch !== 1'b0) begin errors++; $display("[TB] FAIL single_ch got %b ok %0d expected 0", ch, ok); end
    checks++; if (y1 !== 10'd200) begin errors++; $display("[TB] FAIL single_midframe got %0d expected 200", y1); end
    checks++; if (adc_ch !== 1'b1) begin errors++; $display("[TB] FAIL single_toggle got %b expected 1", adc_ch); end
    pulse_frame(a, b, f, fn);
    checks++; if (a !== 10'd249) begin errors++; $display("[TB] FAIL single_y1 got %0d expected 249", a); end
    checks++; if (b !== 10'd200) begin errors++; $display("[TB] FAIL single_y2 got %0d expected 200", b); end
    checks++; if ({f, fn} !== 2'b10) begin errors++; $display("[TB] FAIL single_fresh got %b expected 10", {f, fn}); end
  endtask

  task automatic test_back_to_back();
    logic ch; bit st, ok; logic [9:0] a, b; logic f, fn;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      adc_service(20, 8'd64, 1'b0, ch, st, ok);
      checks++; if (!ok || ch !== 1'(n % 2)) begin errors++; $display("[TB] FAIL b2b_ch%0d got %b ok %0d expected %0d", n, ch, ok, n % 2); end
      checks++; if (!st) begin errors++; $display("[TB] FAIL b2b_stable%0d got unstable expected stable", n); end
    end
    pulse_frame(a, b, f, fn);
    checks++; if (a !== 10'd156 || b !== 10'd156) begin errors++; $display("[TB] FAIL b2b_publish got %0d/%0d expected 156/156", a, b); end
    checks++; if (f !== 1'b1) begin errors++; $display("[TB] FAIL b2b_fresh got %b expected 1", f); end
  endtask

  task automatic test_timeout();
    logic ch; bit st, ok, early; logic [9:0] a, b; logic f, fn;
    ok = 1'b0;
    for (int i = 0; i < 3 * SAMPLE_DIV; i++) begin
      @(posedge clk); #1;
      if (adc_start === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL tmo_start got none expected adc_start"); end
    checks++; if (err !== 1'b0 || adc_ch !== 1'b0) begin errors++; $display("[TB] FAIL tmo_pre got err %b ch %b expected 0 0", err, adc_ch); end
    early = 1'b0;
    for (int k = 1; k < TIMEOUT + 2; k++) begin
      @(posedge clk); #1;
      if (err !== 1'b0) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("[TB] FAIL tmo_early got 1 expected 0"); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_err got %b expected 1", err); end
    checks++; if (adc_ch !== 1'b1) begin errors++; $display("[TB] FAIL tmo_toggle got %b expected 1", adc_ch); end
    pulse_frame(a, b, f, fn);
    checks++; if (a !== 10'd156 || b !== 10'd156 || f !== 1'b0) begin errors++; $display("[TB] FAIL tmo_publish got %0d/%0d fresh %b expected 156/156 fresh 0", a, b, f); end
    adc_service(20, 8'd255, 1'b0, ch, st, ok);
    checks++; if (!ok || ch !== 1'b1) begin errors++; $display("[TB] FAIL tmo_next_ch got %b ok %0d expected 1", ch, ok); end
    pulse_frame(a, b, f, fn);
    checks++; if (a !== 10'd156 || b !== 10'd216 || f !== 1'b1) begin errors++; $display("[TB] FAIL tmo_next_pub got %0d/%0d fresh %b expected 156/216 fresh 1", a, b, f); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_sticky got %b expected 1", err); end
  endtask

  task automatic test_store_coincident();
    logic ch; bit st, ok; logic [9:0] a, b; logic f, fn;
    do_reset();
    adc_service(20, 8'd255, 1'b1, ch, st, ok);
    checks++; if (!ok || y1 !== 10'd200 || fresh !== 1'b0) begin errors++; $display("[TB] FAIL coinc_hold got y1 %0d fresh %b ok %0d expected 200 0", y1, fresh, ok); end
    pulse_frame(a, b, f, fn);
    checks++; if (a !== 10'd249 || f !== 1'b1) begin errors++; $display("[TB] FAIL coinc_next got y1 %0d fresh %b expected 249 1", a, f); end
  endtask

  task automatic test_zero_decay();
    int exp_y[17] = '{150, 112, 84, 63, 47, 35, 26, 19, 14, 10, 7, 5, 3, 2, 1, 0, 0};
    int prev;
    logic ch; bit st, ok; logic [9:0] a, b; logic f, fn;
    do_reset();
    prev = 200;
    for (int s = 0; s < 17; s++) begin
      adc_service(20, 8'd0, 1'b0, ch, st, ok);
      checks++; if (!ok || ch !== 1'b0 || y1 !== 10'(prev)) begin errors++; $display("[TB] FAIL decay_mid%0d got ch %b y1 %0d expected 0 %0d", s, ch, y1, prev); end
      adc_service(20, 8'd0, 1'b0, ch, st, ok);
      pulse_frame(a, b, f, fn);
      checks++; if (a !== 10'(exp_y[s]) || b !== 10'(exp_y[s]) || f !== 1'b1) begin errors++; $display("[TB] FAIL decay_step%0d got %0d/%0d fresh %b expected %0d", s, a, b, f, exp_y[s]); end
      prev = exp_y[s];
    end
  endtask

  task automatic test_reset_abort();
    bit ok; logic [9:0] a, b; logic f, fn;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 3 * SAMPLE_DIV; i++) begin
      @(posedge clk); #1;
      if (adc_start === 1'b1) begin ok = 1'b1; break; end
    end
    adc_busy = 1'b1;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    adc_data = 8'd255;
    adc_busy = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    pulse_frame(a, b, f, fn);
    checks++; if (!ok || a !== 10'd200 || f !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL abort got y1 %0d fresh %b err %b ok %0d expected 200 0 0", a, f, err, ok); end
  endtask

  initial begin
    $display("[TB] paddle_sampler directed test start");
    test_reset();
    test_single_ch0();
    test_back_to_back();
    test_timeout();
    test_store_coincident();
    test_zero_decay();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
